// File: rtl/xrv_pkg.sv
// Shared decode constants, FSM state encoding and RV32I encoders for the xrv_id decode stage.
package xrv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    ST_ISSUE   = 2'd0,
    ST_ALU_WB  = 2'd1,
    ST_LS_WAIT = 2'd2,
    ST_BR_WAIT = 2'd3
  } state_t;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic imm;
    logic rr;
  } ops_t;

  typedef struct packed {
    ops_t        ops;
    logic        is_c;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
  } dec_t;

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/xrv_id_if.sv
// Fetch-side and execute-side signals of the xrv_id decode stage.
interface xrv_id_if;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        ex_jmp;
  logic        ncycle_alu_wait;
  logic        ls_done;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        op_lui;
  logic        op_auipc;
  logic        op_jal;
  logic        op_jalr;
  logic        op_branch;
  logic        op_load;
  logic        op_store;
  logic        op_imm;
  logic        op_reg;
  logic        op_is_compressed;
  logic [31:0] imm_signed;
  logic [31:0] imm_unsigned;
  logic [4:0]  src1;
  logic [4:0]  src2;
  logic [4:0]  dest;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        id_jmp;
  logic [31:0] id_jmp_addr;
  logic        id_illegal;

  modport master (
    output if_valid, if_instr, if_pc, ex_jmp, ncycle_alu_wait, ls_done,
    input  if_ready, ex_valid, ex_pc, op_lui, op_auipc, op_jal, op_jalr, op_branch,
           op_load, op_store, op_imm, op_reg, op_is_compressed, imm_signed, imm_unsigned,
           src1, src2, dest, funct3, funct7, id_jmp, id_jmp_addr, id_illegal
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_jmp, ncycle_alu_wait, ls_done,
    output if_ready, ex_valid, ex_pc, op_lui, op_auipc, op_jal, op_jalr, op_branch,
           op_load, op_store, op_imm, op_reg, op_is_compressed, imm_signed, imm_unsigned,
           src1, src2, dest, funct3, funct7, id_jmp, id_jmp_addr, id_illegal
  );
endinterface

// File: rtl/xrv_rvc_exp.sv
// Combinational RVC-to-RV32I expander, built only with XRV_RVC_EN.
// Unsupported or reserved encodings (including all-zero) raise o_illegal.
module xrv_rvc_exp import xrv_pkg::*; (
  input  logic [15:0] i_cinstr,
  output logic [31:0] o_instr,
  output logic        o_illegal
);
  logic [4:0]  w_rd, w_rs2, w_p42, w_p97;
  logic [11:0] w_imm6, w_spn, w_lsw, w_a16, w_lwsp, w_swsp;
  logic [19:0] w_lui;
  logic [20:1] w_jimm;
  logic [12:1] w_bimm;

  assign w_rd   = i_cinstr[11:7];
  assign w_rs2  = i_cinstr[6:2];
  assign w_p42  = {2'b01, i_cinstr[4:2]};
  assign w_p97  = {2'b01, i_cinstr[9:7]};
  assign w_imm6 = {{6{i_cinstr[12]}}, i_cinstr[12], i_cinstr[6:2]};
  assign w_spn  = {2'b00, i_cinstr[10:7], i_cinstr[12:11], i_cinstr[5], i_cinstr[6], 2'b00};
  assign w_lsw  = {5'b0, i_cinstr[5], i_cinstr[12:10], i_cinstr[6], 2'b00};
  assign w_a16  = {{2{i_cinstr[12]}}, i_cinstr[12], i_cinstr[4:3], i_cinstr[5], i_cinstr[2],
                   i_cinstr[6], 4'b0000};
  assign w_lwsp = {4'b0, i_cinstr[3:2], i_cinstr[12], i_cinstr[6:4], 2'b00};
  assign w_swsp = {4'b0, i_cinstr[8:7], i_cinstr[12:9], 2'b00};
  assign w_lui  = {{14{i_cinstr[12]}}, i_cinstr[12], i_cinstr[6:2]};
  assign w_jimm = {{9{i_cinstr[12]}}, i_cinstr[12], i_cinstr[8], i_cinstr[10:9], i_cinstr[6],
                   i_cinstr[7], i_cinstr[2], i_cinstr[11], i_cinstr[5:3]};
  assign w_bimm = {{4{i_cinstr[12]}}, i_cinstr[12], i_cinstr[6:5], i_cinstr[2],
                   i_cinstr[11:10], i_cinstr[4:3]};

  // Case key is {quadrant, funct3}.
  always_comb begin
    o_instr   = '0;
    o_illegal = 1'b0;
    case ({i_cinstr[1:0], i_cinstr[15:13]})
      5'b00_000: begin
        o_instr   = enc_i(w_spn, 5'd2, F3_ADD, w_p42, OPC_OP_IMM);
        o_illegal = (w_spn == 12'd0);
      end
      5'b00_010: o_instr = enc_i(w_lsw, w_p97, F3_LW, w_p42, OPC_LOAD);
      5'b00_110: o_instr = enc_s(w_lsw, w_p42, w_p97, F3_SW);
      5'b01_000: o_instr = enc_i(w_imm6, w_rd, F3_ADD, w_rd, OPC_OP_IMM);
      5'b01_001: o_instr = enc_j(w_jimm, 5'd1);
      5'b01_010: o_instr = enc_i(w_imm6, 5'd0, F3_ADD, w_rd, OPC_OP_IMM);
      5'b01_011: begin
        if (w_rd == 5'd2) begin
          o_instr = enc_i(w_a16, 5'd2, F3_ADD, 5'd2, OPC_OP_IMM);
        end else begin
          o_instr = {w_lui, w_rd, OPC_LUI};
        end
        o_illegal = ({i_cinstr[12], i_cinstr[6:2]} == 6'd0);
      end
      5'b01_100: begin
        case (i_cinstr[11:10])
          2'b00: begin
            o_instr   = enc_i({7'b0, i_cinstr[6:2]}, w_p97, F3_SR, w_p97, OPC_OP_IMM);
            o_illegal = i_cinstr[12];
          end
          2'b01: begin
            o_instr   = enc_i({7'b0100000, i_cinstr[6:2]}, w_p97, F3_SR, w_p97, OPC_OP_IMM);
            o_illegal = i_cinstr[12];
          end
          2'b10: o_instr = enc_i(w_imm6, w_p97, F3_AND, w_p97, OPC_OP_IMM);
          default: begin
            o_illegal = i_cinstr[12];
            case (i_cinstr[6:5])
              2'b00:   o_instr = enc_r(7'b0100000, w_p42, w_p97, F3_ADD, w_p97);
              2'b01:   o_instr = enc_r(7'b0, w_p42, w_p97, F3_XOR, w_p97);
              2'b10:   o_instr = enc_r(7'b0, w_p42, w_p97, F3_OR, w_p97);
              default: o_instr = enc_r(7'b0, w_p42, w_p97, F3_AND, w_p97);
            endcase
          end
        endcase
      end
      5'b01_101: o_instr = enc_j(w_jimm, 5'd0);
      5'b01_110: o_instr = enc_b(w_bimm, 5'd0, w_p97, F3_BEQ);
      5'b01_111: o_instr = enc_b(w_bimm, 5'd0, w_p97, F3_BNE);
      5'b10_000: begin
        o_instr   = enc_i({7'b0, i_cinstr[6:2]}, w_rd, F3_SLL, w_rd, OPC_OP_IMM);
        o_illegal = i_cinstr[12];
      end
      5'b10_010: begin
        o_instr   = enc_i(w_lwsp, 5'd2, F3_LW, w_rd, OPC_LOAD);
        o_illegal = (w_rd == 5'd0);
      end
      5'b10_100: begin
        if (w_rs2 == 5'd0) begin
          o_instr   = enc_i(12'd0, w_rd, F3_ADD, {4'b0, i_cinstr[12]}, OPC_JALR);
          o_illegal = (w_rd == 5'd0);
        end else if (!i_cinstr[12]) begin
          o_instr = enc_r(7'b0, w_rs2, 5'd0, F3_ADD, w_rd);
        end else begin
          o_instr = enc_r(7'b0, w_rs2, w_rd, F3_ADD, w_rd);
        end
      end
      5'b10_110: o_instr = enc_s(w_swsp, w_rs2, 5'd2, F3_SW);
      default:   o_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/xrv_id.sv
// Decode stage: captures one fetch word, registers decoded fields, paces issue with a 4-state FSM.
// XRV_RVC_EN enables compressed-instruction expansion; otherwise non-32-bit words are illegal.
module xrv_id import xrv_pkg::*; (
  input logic     clk,
  input logic     rstb,
  xrv_id_if.slave bus
);
  state_t      r_state, w_state_nxt;
  dec_t        r_dec, w_dec;
  logic        r_ex_valid, r_id_jmp, r_id_illegal;
  logic [31:0] r_ex_pc, r_id_jmp_addr;
  logic [31:0] w_instr;
  logic        w_is_c, w_c_ill, w_illegal, w_if_ready, w_accept, w_busy;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;

`ifdef XRV_RVC_EN
  logic [31:0] w_exp_instr;
  logic        w_exp_ill;

  xrv_rvc_exp u_rvc_exp (
    .i_cinstr  (bus.if_instr[15:0]),
    .o_instr   (w_exp_instr),
    .o_illegal (w_exp_ill)
  );

  assign w_is_c  = (bus.if_instr[1:0] != 2'b11);
  assign w_instr = w_is_c ? w_exp_instr : bus.if_instr;
  assign w_c_ill = w_is_c & w_exp_ill;
`else
  assign w_is_c  = 1'b0;
  assign w_instr = bus.if_instr;
  assign w_c_ill = (bus.if_instr[1:0] != 2'b11);
`endif

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                    w_instr[11:8], 1'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                    w_instr[30:21], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};

  always_comb begin
    w_dec       = '0;
    w_illegal   = 1'b0;
    w_dec.is_c  = w_is_c;
    w_dec.rs1   = w_instr[19:15];
    w_dec.rs2   = w_instr[24:20];
    w_dec.rd    = w_instr[11:7];
    w_dec.f3    = w_instr[14:12];
    w_dec.f7    = w_instr[31:25];
    w_dec.imm_u = {20'b0, w_instr[31:20]};
    case (w_instr[6:0])
      OPC_LUI:    begin w_dec.ops.lui    = 1'b1; w_dec.imm_s = w_imm_u; end
      OPC_AUIPC:  begin w_dec.ops.auipc  = 1'b1; w_dec.imm_s = w_imm_u; end
      OPC_JAL:    begin w_dec.ops.jal    = 1'b1; w_dec.imm_s = w_imm_j; end
      OPC_JALR:   begin w_dec.ops.jalr   = 1'b1; w_dec.imm_s = w_imm_i; end
      OPC_BRANCH: begin w_dec.ops.branch = 1'b1; w_dec.imm_s = w_imm_b; end
      OPC_LOAD:   begin w_dec.ops.load   = 1'b1; w_dec.imm_s = w_imm_i; end
      OPC_STORE:  begin w_dec.ops.store  = 1'b1; w_dec.imm_s = w_imm_s; end
      OPC_OP_IMM: begin w_dec.ops.imm    = 1'b1; w_dec.imm_s = w_imm_i; end
      OPC_OP:     begin w_dec.ops.rr     = 1'b1; end
      default:    w_illegal = 1'b1;
    endcase
    if (w_c_ill) begin
      w_illegal = 1'b1;
    end
    if (w_illegal) begin
      w_dec.ops  = '0;
      w_dec.is_c = 1'b0;
    end
  end

  // Only classes that leave ISSUE block the next fetch during their issue cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = r_ex_valid & (r_dec.ops.imm | r_dec.ops.rr | r_dec.ops.load | r_dec.ops.store |
                                r_dec.ops.branch | r_dec.ops.jalr | r_dec.ops.jal);
    w_if_ready  = rstb & (r_state == ST_ISSUE) & ~bus.ex_jmp & ~w_busy;
    case (r_state)
      ST_ISSUE: begin
        if (r_ex_valid) begin
          if (r_dec.ops.imm | r_dec.ops.rr) begin
            w_state_nxt = ST_ALU_WB;
          end else if (r_dec.ops.load | r_dec.ops.store) begin
            w_state_nxt = bus.ls_done ? ST_ISSUE : ST_LS_WAIT;
          end else if (r_dec.ops.branch | r_dec.ops.jalr | r_dec.ops.jal) begin
            w_state_nxt = ST_BR_WAIT;
          end
        end
      end
      ST_ALU_WB:  w_state_nxt = ST_ISSUE;
      ST_LS_WAIT: if (bus.ls_done) w_state_nxt = ST_ISSUE;
      ST_BR_WAIT: w_state_nxt = ST_ISSUE;
      default:    w_state_nxt = ST_ISSUE;
    endcase
  end

  assign w_accept = bus.if_valid & w_if_ready;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state       <= ST_ISSUE;
      r_dec         <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_id_jmp      <= 1'b0;
      r_id_jmp_addr <= '0;
      r_id_illegal  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ex_valid   <= w_accept & ~w_illegal;
      r_id_illegal <= w_accept & w_illegal;
      r_id_jmp     <= r_ex_valid & r_dec.ops.jal;
      if (r_ex_valid & r_dec.ops.jal) begin
        r_id_jmp_addr <= r_ex_pc + r_dec.imm_s;
      end
      if (w_accept) begin
        r_dec   <= w_dec;
        r_ex_pc <= bus.if_pc;
      end
    end
  end

  assign bus.if_ready         = w_if_ready;
  assign bus.ex_valid         = r_ex_valid;
  assign bus.ex_pc            = r_ex_pc;
  assign bus.op_lui           = r_dec.ops.lui;
  assign bus.op_auipc         = r_dec.ops.auipc;
  assign bus.op_jal           = r_dec.ops.jal;
  assign bus.op_jalr          = r_dec.ops.jalr;
  assign bus.op_branch        = r_dec.ops.branch;
  assign bus.op_load          = r_dec.ops.load;
  assign bus.op_store         = r_dec.ops.store;
  assign bus.op_imm           = r_dec.ops.imm;
  assign bus.op_reg           = r_dec.ops.rr;
  assign bus.op_is_compressed = r_dec.is_c;
  assign bus.imm_signed       = r_dec.imm_s;
  assign bus.imm_unsigned     = r_dec.imm_u;
  assign bus.src1             = r_dec.rs1;
  assign bus.src2             = r_dec.rs2;
  assign bus.dest             = r_dec.rd;
  assign bus.funct3           = r_dec.f3;
  assign bus.funct7           = r_dec.f7;
  assign bus.id_jmp           = r_id_jmp;
  assign bus.id_jmp_addr      = r_id_jmp_addr;
  assign bus.id_illegal       = r_id_illegal;
endmodule

// File: tb/tb_xrv_id.sv
// Directed bench for xrv_id: ALU, load, JAL, taken branch, illegal, compressed and reset scenarios.
module tb_xrv_id;
  logic clk = 1'b0;
  logic rstb;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [8:0] w_ops;

  xrv_id_if bus ();

  xrv_id dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Flag order: lui auipc jal jalr branch load store imm reg
  assign w_ops = {bus.op_lui, bus.op_auipc, bus.op_jal, bus.op_jalr, bus.op_branch,
                  bus.op_load, bus.op_store, bus.op_imm, bus.op_reg};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = instr;
    bus.if_pc    = pc;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstb = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.ex_jmp = 1'b0;
    bus.ncycle_alu_wait = 1'b0;
    bus.ls_done = 1'b0;
    tick();
    tick();
    chk("rst_if_ready", bus.if_ready, 1'b0);
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ops", w_ops, 9'h000);
    chk("rst_id_jmp", bus.id_jmp, 1'b0);
    chk("rst_id_illegal", bus.id_illegal, 1'b0);
    chk("rst_ex_pc", bus.ex_pc, 32'h0);
    chk("rst_imm", bus.imm_signed, 32'h0);
    rstb = 1'b1;
    #1;
    chk("rel_if_ready", bus.if_ready, 1'b1);

    // addi x1,x0,5
    drive(1'b1, 32'h00500093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    bus.ncycle_alu_wait = 1'b1;
    chk("addi_ex_valid", bus.ex_valid, 1'b1);
    chk("addi_ops", w_ops, 9'h002);
    chk("addi_dest", bus.dest, 5'd1);
    chk("addi_imm", bus.imm_signed, 32'd5);
    chk("addi_ex_pc", bus.ex_pc, 32'h100);
    chk("addi_rdy_issue", bus.if_ready, 1'b0);
    tick();
    bus.ncycle_alu_wait = 1'b0;
    chk("addi_wb_valid", bus.ex_valid, 1'b0);
    chk("addi_wb_rdy", bus.if_ready, 1'b0);
    tick();
    chk("addi_rdy_back", bus.if_ready, 1'b1);

    // lw x2,8(x1); a lui stays offered on the fetch side throughout
    drive(1'b1, 32'h0080A103, 32'h104);
    tick();
    drive(1'b1, 32'h123452B7, 32'h108);
    chk("lw_ex_valid", bus.ex_valid, 1'b1);
    chk("lw_ops", w_ops, 9'h008);
    chk("lw_src1", bus.src1, 5'd1);
    chk("lw_imm", bus.imm_signed, 32'd8);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_wait_rdy", bus.if_ready, 1'b0);
      chk("lw_wait_valid", bus.ex_valid, 1'b0);
      chk("lw_wait_f3", bus.funct3, 3'd2);
      chk("lw_wait_dest", bus.dest, 5'd2);
    end
    tick();
    bus.ls_done = 1'b1;
    #1;
    chk("lw_done_rdy", bus.if_ready, 1'b0);
    chk("lw_done_dest", bus.dest, 5'd2);
    tick();
    bus.ls_done = 1'b0;
    chk("lw_issue_rdy", bus.if_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("lui_ex_valid", bus.ex_valid, 1'b1);
    chk("lui_ops", w_ops, 9'h100);
    chk("lui_imm", bus.imm_signed, 32'h12345000);
    chk("lui_imm_u", bus.imm_unsigned, 32'h00000123);
    chk("lui_dest", bus.dest, 5'd5);
    chk("lui_rdy", bus.if_ready, 1'b1);

    // jal x1,+0x100 at 0x200
    drive(1'b1, 32'h100000EF, 32'h200);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("jal_ops", w_ops, 9'h040);
    chk("jal_imm", bus.imm_signed, 32'h100);
    chk("jal_id_jmp_early", bus.id_jmp, 1'b0);
    tick();
    chk("jal_id_jmp", bus.id_jmp, 1'b1);
    chk("jal_addr", bus.id_jmp_addr, 32'h300);
    chk("jal_bubble_valid", bus.ex_valid, 1'b0);
    chk("jal_bubble_rdy", bus.if_ready, 1'b0);
    tick();
    chk("jal_id_jmp_end", bus.id_jmp, 1'b0);
    chk("jal_rdy_back", bus.if_ready, 1'b1);

    // beq x1,x2,+8 taken, addi x3,x0,7 held on the fetch side
    drive(1'b1, 32'h00208463, 32'h300);
    tick();
    drive(1'b1, 32'h00700193, 32'h308);
    chk("beq_ops", w_ops, 9'h010);
    chk("beq_imm", bus.imm_signed, 32'd8);
    chk("beq_src2", bus.src2, 5'd2);
    tick();
    bus.ex_jmp = 1'b1;
    #1;
    chk("beq_bw_rdy", bus.if_ready, 1'b0);
    tick();
    bus.ex_jmp = 1'b0;
    #1;
    chk("beq_no_capture", bus.ex_valid, 1'b0);
    chk("beq_rdy_back", bus.if_ready, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("beq_next_valid", bus.ex_valid, 1'b1);
    chk("beq_next_pc", bus.ex_pc, 32'h308);
    chk("beq_next_dest", bus.dest, 5'd3);
    tick();
    tick();
    bus.ex_jmp = 1'b1;
    #1;
    chk("exjmp_blocks_rdy", bus.if_ready, 1'b0);
    bus.ex_jmp = 1'b0;
    #1;
    chk("exjmp_release_rdy", bus.if_ready, 1'b1);

    // illegal word
    drive(1'b1, 32'hFFFFFFFF, 32'h400);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("ill_pulse", bus.id_illegal, 1'b1);
    chk("ill_ex_valid", bus.ex_valid, 1'b0);
    chk("ill_ops", w_ops, 9'h000);
    chk("ill_rdy", bus.if_ready, 1'b1);
    tick();
    chk("ill_pulse_end", bus.id_illegal, 1'b0);

    // c.addi x1,1
    drive(1'b1, 32'h00000085, 32'h500);
    tick();
    drive(1'b0, 32'h0, 32'h0);
`ifdef XRV_RVC_EN
    chk("rvc_ex_valid", bus.ex_valid, 1'b1);
    chk("rvc_ops", w_ops, 9'h002);
    chk("rvc_is_c", bus.op_is_compressed, 1'b1);
    chk("rvc_imm", bus.imm_signed, 32'd1);
    chk("rvc_dest", bus.dest, 5'd1);
    tick();
    tick();
`else
    chk("rvc_off_illegal", bus.id_illegal, 1'b1);
    chk("rvc_off_valid", bus.ex_valid, 1'b0);
    chk("rvc_off_is_c", bus.op_is_compressed, 1'b0);
    tick();
`endif
    chk("rvc_rdy", bus.if_ready, 1'b1);

    // sw x2,4(x1), then reset while waiting for ls_done
    drive(1'b1, 32'h0020A223, 32'h600);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("sw_ops", w_ops, 9'h004);
    chk("sw_imm", bus.imm_signed, 32'd4);
    tick();
    chk("sw_wait_rdy", bus.if_ready, 1'b0);
    #2;
    rstb = 1'b0;
    #1;
    chk("mid_rst_rdy", bus.if_ready, 1'b0);
    chk("mid_rst_ops", w_ops, 9'h000);
    chk("mid_rst_imm", bus.imm_signed, 32'h0);
    chk("mid_rst_f3", bus.funct3, 3'd0);
    chk("mid_rst_pc", bus.ex_pc, 32'h0);
    chk("mid_rst_jaddr", bus.id_jmp_addr, 32'h0);
    tick();
    rstb = 1'b1;
    #1;
    chk("mid_rst_issue_rdy", bus.if_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
